// File: rtl/rr_mux_4x1.sv
// Purpose : merge four valid/ready source channels onto one registered output,
//           round-robin arbitration, each word tagged with its 2-bit channel id.
// Latency : 1 cycle from input handshake to out_valid; 1 word/cycle sustained.
// Backpressure: out_ready low with a held word drops every in_ready; the held
//           word stays stable. Accept and refill happen in the same cycle.
//
// Optional build macro: RR_MUX_FIXED_PRIO_EN
//   undefined : round-robin, scan starts at ptr (the channel after the last grant).
//   defined   : fixed priority, channel 0 highest, channel 3 lowest; no ptr state.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (async assert, sync release upstream)
//   in_valid   per-channel valid, bit i = channel i
//   in_data    packed channel data, channel i at [i*W +: W]
//   in_ready   per-channel ready (one-hot grant or zero)
//   out_valid  output register holds a word
//   out_data   registered data of the granted channel
//   out_sel    channel id of the word in out_data
//   out_ready  downstream accepts when out_valid & out_ready
module rr_mux_4x1 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_sel,
    input  logic           out_ready
);

    // The output register may take a new word when it is empty or being drained.
    logic       load;
    logic [1:0] scan_start;
    logic [1:0] grant_idx;
    logic       grant_any;
    logic [1:0] scan_idx;

    assign load = !out_valid || out_ready;

`ifdef RR_MUX_FIXED_PRIO_EN
    // Fixed priority: every scan begins at channel 0.
    assign scan_start = 2'd0;
`else
    // Round-robin pointer: the channel that gets first look on the next grant.
    logic [1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (load && grant_any) begin
            // 2-bit add wraps 3 back to 0.
            ptr <= grant_idx + 2'd1;
        end
    end

    assign scan_start = ptr;
`endif

    // Scan start, start+1, start+2, start+3 (mod 4). Iterating from the far end
    // back toward the start lets the nearest requesting channel overwrite the
    // others, so the first hit in scan order wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = scan_start;
        scan_idx  = scan_start;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = scan_start + 2'(k);
            if (in_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Ready is gated by rst_n so no source sees a handshake while in reset,
    // even though out_valid=0 makes load true during that time.
    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && load && grant_any) begin
            in_ready = 4'b0001 << grant_idx;
        end
    end

    // Output register. On load with no request only out_valid clears; data and
    // sel keep their last values (they are meaningless while out_valid=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
        end else if (load) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx*W +: W];
                out_sel   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_4x1.sv
module tb_rr_mux_4x1;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: what the output register should hold.
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;
    int         m_ptr;

    rr_mux_4x1 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requesting channel in order start, start+1, ... (mod 4); -1 if none.
    function automatic int pick(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            if (v[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 8'h00;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_valid);
        chk({tag, ".out_data"},  out_data,  m_data);
        chk({tag, ".out_sel"},   out_sel,   m_sel);
    endtask

    // Called just after inputs are driven (post-negedge). Checks in_ready,
    // advances one clock, updates the model, checks outputs at the next negedge.
    task automatic cycle(input string tag);
        bit load;
        int g;
        int start;
`ifdef RR_MUX_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        load = !m_valid || out_ready;
        g    = load ? pick(in_valid, start) : -1;
        #1;
        chk({tag, ".in_ready"}, in_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        if (load) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = in_data[g*W +: W];
                m_sel   = g;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.in_ready", in_ready, 4'b0000);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_rot[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
        model_reset();

        // Reset with all channels requesting.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.out_data",  out_data,  8'h00);
        chk("reset.out_sel",   out_sel,   2'b00);
        chk("reset.in_ready",  in_ready,  4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("first");
        chk("first.sel", out_sel, 2'd0);

        // Single channel.
        do_reset();
        in_valid = 4'b0100;
        in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        cycle("single");
        chk("single.valid", out_valid, 1'b1);
        chk("single.data",  out_data,  8'hA5);
        chk("single.sel",   out_sel,   2'b10);
        in_valid = 4'b0000;
        cycle("single_idle");
        chk("single_idle.valid", out_valid, 1'b0);

        // Fair rotation.
        do_reset();
        in_valid = 4'b1111;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 6; i++) begin
            cycle("rot");
`ifdef RR_MUX_FIXED_PRIO_EN
            chk("rot.sel",  out_sel,  2'd0);
            chk("rot.data", out_data, 8'h10);
`else
            chk("rot.sel",  out_sel,  exp_rot[i]);
            chk("rot.data", out_data, 8'h10 + exp_rot[i]);
`endif
        end

        // Back-pressure: hold for 3 cycles, then accept + refill from ch2.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall.in_ready", in_ready, 4'b0000);
`ifndef RR_MUX_FIXED_PRIO_EN
            chk("stall.data", out_data, 8'h11);
            chk("stall.sel",  out_sel,  2'd1);
`endif
        end
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        cycle("refill");
        chk("refill.valid", out_valid, 1'b1);
        chk("refill.sel",   out_sel,   2'd2);
        chk("refill.data",  out_data,  8'h12);

        // Wrap: grant ch3, then ch0 and ch3 requesting.
        in_valid = 4'b1000;
        cycle("wrap_pre");
        chk("wrap_pre.sel", out_sel, 2'd3);
        in_valid = 4'b1001;
        cycle("wrap0");
        chk("wrap0.sel", out_sel, 2'd0);
        cycle("wrap1");
`ifdef RR_MUX_FIXED_PRIO_EN
        chk("wrap1.sel", out_sel, 2'd0);
`else
        chk("wrap1.sel", out_sel, 2'd3);
`endif

        // Mid-operation reset: out_valid must drop without a clock edge.
        in_valid = 4'b0010;
        cycle("mid_pre");
        chk("mid_pre.valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.valid",    out_valid, 1'b0);
        chk("mid_rst.in_ready", in_ready,  4'b0000);
        model_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b1000;
        cycle("mid_post");
        chk("mid_post.sel", out_sel, 2'b11);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
